// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Architectural PC register with imem request handshake, stall,
//               redirect and sticky misaligned-target error.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [31:0] fetched_pc,
    output logic        misalign_err
);

    localparam logic [31:0] c_pc_step = PC_STEP[31:0];

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetched_pc_q, fetched_pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        err_q, err_d;
    logic        w_target_misaligned;

    assign w_target_misaligned = |redirect_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            fetched_pc_q  <= 32'h0000_0000;
            fetch_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetched_pc_q  <= fetched_pc_d;
            fetch_valid_q <= fetch_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetched_pc_d  = fetched_pc_q;
        fetch_valid_d = 1'b0;
        err_d         = err_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Redirect wins over stall and abandons any in-flight request.
                if (redirect_valid) begin
                    if (w_target_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!stall && imem_ready) begin
                    fetched_pc_d  = pc_q;
                    fetch_valid_d = 1'b1;
                    pc_d          = pc_q + c_pc_step;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Request depends only on registered state and stall, never on data paths.
    assign imem_req     = (state_q == S_FETCH) & ~stall;
    assign pc_out       = pc_q;
    assign pc_plus4     = pc_q + c_pc_step;
    assign fetch_valid  = fetch_valid_q;
    assign fetched_pc   = fetched_pc_q;
    assign misalign_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit (model + directed/random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] fetched_pc;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;
    bit en       = 1'b0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .fetched_pc      (fetched_pc),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: phase 0 = booting, 1 = fetching, 2 = halted on bad target.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    bit          m_fv;
    bit          m_err;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_pc    <= 32'h0;
            m_fpc   <= 32'h0;
            m_fv    <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_phase == 0) begin
            m_phase <= 1;
            m_fv    <= 1'b0;
        end else if (m_phase == 2) begin
            m_fv <= 1'b0;
        end else if (redirect_valid) begin
            m_fv <= 1'b0;
            if (redirect_target % 4 == 0) begin
                m_pc <= redirect_target;
            end else begin
                m_err   <= 1'b1;
                m_phase <= 2;
            end
        end else if (!stall && imem_ready) begin
            m_fpc <= m_pc;
            m_fv  <= 1'b1;
            m_pc  <= m_pc + 32'd4;
        end else begin
            m_fv <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            #1;
            chk("req",       {31'd0, imem_req},     {31'd0, (m_phase == 1) && !stall});
            chk("pc_out",    pc_out,                m_pc);
            chk("pc_plus4",  pc_plus4,              m_pc + 32'd4);
            chk("fetch_vld", {31'd0, fetch_valid},  {31'd0, m_fv});
            chk("fetch_pc",  fetched_pc,            m_fpc);
            chk("err",       {31'd0, misalign_err}, {31'd0, m_err});
        end
    end

    task automatic drive(input bit r, input bit st, input bit rv,
                         input logic [31:0] tgt, input bit rdy);
        @(negedge clk);
        reset           = r;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_ready      = rdy;
        #2;
    endtask

    initial begin
        logic [31:0] tmp;
        bit          r, st, rv, rdy;
        logic [31:0] tgt;

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; imem_ready = 1'b0;
        en = 1'b1;

        // Boot then streaming fetches 0,4,8,12
        repeat (3) drive(1, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        chk("lit_boot_req", {31'd0, imem_req}, 32'd0);
        chk("lit_boot_pc",  pc_out, 32'h0);
        drive(0, 0, 0, 32'h0, 1);
        chk("lit_first_req", {31'd0, imem_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 32'h0, (k < 3));
            chk("lit_stream_fv",  {31'd0, fetch_valid}, 32'd1);
            chk("lit_stream_fpc", fetched_pc, 32'(4 * k));
        end

        // imem not ready holds PC at 0x10
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 0, 32'h0, 0);
            chk("lit_wait_pc",  pc_out, 32'h10);
            chk("lit_wait_req", {31'd0, imem_req}, 32'd1);
            chk("lit_wait_fv",  {31'd0, fetch_valid}, 32'd0);
        end
        drive(0, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 0);
        chk("lit_ready_fv",  {31'd0, fetch_valid}, 32'd1);
        chk("lit_ready_fpc", fetched_pc, 32'h10);
        chk("lit_ready_pc",  pc_out, 32'h14);

        // Redirect during stall, then plain stall
        drive(0, 1, 1, 32'h400, 1);
        drive(0, 1, 0, 32'h0, 1);
        chk("lit_redir_pc", pc_out, 32'h400);
        chk("lit_redir_fv", {31'd0, fetch_valid}, 32'd0);
        chk("lit_stall_req", {31'd0, imem_req}, 32'd0);
        drive(0, 1, 0, 32'h0, 1);
        chk("lit_stall_pc", pc_out, 32'h400);

        // Wrap at the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 32'h0, 1);
        chk("lit_wrap_pre", pc_out, 32'hFFFF_FFFC);
        drive(0, 0, 0, 32'h0, 0);
        chk("lit_wrap_fpc", fetched_pc, 32'hFFFF_FFFC);
        chk("lit_wrap_pc",  pc_out, 32'h0);
        chk("lit_wrap_p4",  pc_plus4, 32'h4);
        chk("lit_wrap_err", {31'd0, misalign_err}, 32'd0);

        // Misaligned redirect halts until reset
        drive(0, 0, 1, 32'h402, 1);
        for (int j = 0; j < 10; j++) begin
            drive(0, 0, 1, 32'h800, 1);
            chk("lit_halt_err", {31'd0, misalign_err}, 32'd1);
            chk("lit_halt_req", {31'd0, imem_req}, 32'd0);
            chk("lit_halt_pc",  pc_out, 32'h0);
        end
        drive(1, 0, 0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 1);
        chk("lit_clr_err", {31'd0, misalign_err}, 32'd0);
        chk("lit_clr_req", {31'd0, imem_req}, 32'd0);

        // Mid-stream reset at 0x20, redirect in boot ignored
        for (int k = 0; k < 9; k++) begin
            drive((k == 8), 0, 0, 32'h0, 1);
            chk("lit_run_pc", pc_out, 32'(4 * k));
        end
        drive(0, 0, 1, 32'h80, 1);
        chk("lit_rst_pc",  pc_out, 32'h0);
        chk("lit_rst_fv",  {31'd0, fetch_valid}, 32'd0);
        chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
        drive(0, 0, 0, 32'h0, 1);
        chk("lit_bootredir_pc", pc_out, 32'h0);

        // Randomized traffic checked by the model every cycle
        repeat (3000) begin
            r   = ($urandom_range(0, 63) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tmp = $urandom;
            case ($urandom_range(0, 7))
                0:       tgt = tmp;
                1:       tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: tgt = {tmp[31:2], 2'b00};
            endcase
            drive(r, st, rv, tgt, rdy);
        end
        drive(0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
